// File: rtl/lu_arbiter.sv
// Two-requester front end for one shared AND/NAND logic unit: accept one op, run it, return the result.
// Optional build macro LU_ARB_FIXED_PRIO_EN: req0 always wins ties instead of round-robin.
module lu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic             lu_sel,
  input  logic [WIDTH-1:0] lu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Ready is only offered in IDLE and to at most one requester; response valid holds until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic             lu_sel_q, lu_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;

  logic both_valid;
  logic any_valid;
  logic grant;
  logic accept;

  assign both_valid = req0_valid & req1_valid;
  assign any_valid  = req0_valid | req1_valid;

`ifdef LU_ARB_FIXED_PRIO_EN
  assign grant = both_valid ? 1'b0 : ~req0_valid;
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time is served.
  assign grant = both_valid ? ~last_grant_q : ~req0_valid;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && any_valid) begin
      last_grant_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Ready is gated by rst_n so nothing is accepted while reset is asserted.
  assign accept     = rst_n & (state_q == S_IDLE) & any_valid;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  always_comb begin
    state_d     = state_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_sel_d    = lu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          lu_a_d   = grant ? req1_a  : req0_a;
          lu_b_d   = grant ? req1_b  : req0_b;
          lu_sel_d = grant ? req1_op : req0_op;
          rsp_id_d = grant;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands have been stable on the LU for a full cycle; capture its result.
        rsp_data_d  = lu_s;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_sel_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_sel_q    <= lu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign lu_a        = lu_a_q;
  assign lu_b        = lu_b_q;
  assign lu_sel      = lu_sel_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Bench for lu_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_lu_arbiter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [WIDTH-1:0] lu_a, lu_b, lu_s;
  logic             lu_sel;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  // Shared logic unit lives in the environment.
  assign lu_s = lu_sel ? ~(lu_a & lu_b) : (lu_a & lu_b);

  lu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_s(lu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: outstanding op {id,result}, its operands, accept cycle, last tie winner.
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] pend_a, pend_b;
  logic             pend_sel;
  int               cyc = 0;
  int               acc_cyc = 0;
  int               last_winner = 1;
  int               g_id[$];
  int               g_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge, update the model.
  task automatic step(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic o0, input logic v1, input logic [WIDTH-1:0] a1,
                      input logic [WIDTH-1:0] b1, input logic o1, input logic rr);
    logic free, er0, er1, erv;
    int   winner;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready  = rr;
    #1;
    free = (exp_q.size() == 0);
    if (v0 && v1) begin
`ifdef LU_ARB_FIXED_PRIO_EN
      winner = 0;
`else
      winner = (last_winner == 0) ? 1 : 0;
`endif
    end else begin
      winner = v0 ? 0 : 1;
    end
    er0 = rst_n && free && v0 && (winner == 0);
    er1 = rst_n && free && v1 && (winner == 1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
    erv = !free && (cyc >= acc_cyc + 2);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, erv});
    if (erv) begin
      chk("rsp_data", {28'd0, rsp_data}, {28'd0, exp_q[0][WIDTH-1:0]});
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0][WIDTH]});
    end
    if (!free && cyc == acc_cyc + 1) begin
      chk("lu_a", {28'd0, lu_a}, {28'd0, pend_a});
      chk("lu_b", {28'd0, lu_b}, {28'd0, pend_b});
      chk("lu_sel", {31'd0, lu_sel}, {31'd0, pend_sel});
    end
    if (!rst_n) begin
      exp_q.delete();
      last_winner = 1;
    end else begin
      if (erv && rr) void'(exp_q.pop_front());
      if (er0 || er1) begin
        pend_a   = er0 ? a0 : a1;
        pend_b   = er0 ? b0 : b1;
        pend_sel = er0 ? o0 : o1;
        exp_q.push_back({er1, pend_sel ? ~(pend_a & pend_b) : (pend_a & pend_b)});
        last_winner = er0 ? 0 : 1;
        acc_cyc = cyc;
        g_id.push_back(er0 ? 0 : 1);
        g_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step(input logic rr);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rr);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with both requesters asking: nothing accepted, everything cleared.
    step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
    step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
    chk("rst_lu_a", {28'd0, lu_a}, 32'd0);
    chk("rst_lu_b", {28'd0, lu_b}, 32'd0);
    chk("rst_lu_sel", {31'd0, lu_sel}, 32'd0);
    chk("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    rst_n = 1'b1;

    // AND from requester 0.
    step(1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle_step(1'b1);
    chk("t2_rsp_data", {28'd0, rsp_data}, 32'b1000);
    chk("t2_rsp_id", {31'd0, rsp_id}, 32'd0);
    idle_step(1'b1);
    idle_step(1'b1);

    // NAND from requester 1.
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b1, 1'b1);
    chk("t3_lu_sel", {31'd0, lu_sel}, 32'd1);
    idle_step(1'b1);
    chk("t3_rsp_data", {28'd0, rsp_data}, 32'b0111);
    chk("t3_rsp_id", {31'd0, rsp_id}, 32'd1);
    idle_step(1'b1);
    idle_step(1'b1);

    // Response back-pressure for five cycles while both requesters wait, then release.
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'b0110, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 4'h5, 4'h3, 1'b0, 1'b1, 4'h9, 4'h6, 1'b1, 1'b0);
    chk("t5_rsp_data", {28'd0, rsp_data}, 32'b0010);
    idle_step(1'b1);
    idle_step(1'b0);

    // Reset during EXEC: operation dropped, no response.
    step(1'b1, 4'hF, 4'hE, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    idle_step(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_step(1'b1);

    // Both requesters valid continuously straight after reset: fixed grant pattern every 3 cycles.
    g_id.delete();
    g_cyc.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 4'hA, 4'hC, 1'b0, 1'b1, 4'h3, 4'h7, 1'b1, 1'b1);
    chk("t4_grant_count", g_id.size(), 32'd4);
    for (int i = 0; i < 4 && i < g_id.size(); i++) begin
`ifdef LU_ARB_FIXED_PRIO_EN
      chk($sformatf("t4_grant%0d", i), g_id[i], 32'd0);
`else
      chk($sformatf("t4_grant%0d", i), g_id[i], (i % 2 == 0) ? 32'd0 : 32'd1);
`endif
      if (i > 0) chk($sformatf("t4_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 32'd3);
    end

    // Random traffic with valids that may drop, random operands and random back-pressure.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 6), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle_step(1'b1);
    chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
